fetch_unit: RTL

Instruction fetch sequencer that produces the instruction stream consumed by the CPU's instruction register. It holds the program counter, performs a request/acknowledge read from instruction memory, and presents each fetched word with a single-cycle load strobe for the instruction register. It sits between the control unit, which requests fetches and redirects, and the instruction memory port.

---
 rtl/fetch_if.sv | 26 ++
 rtl/fetch_unit.sv | 92 +++++++++
 2 files changed

// File: rtl/fetch_if.sv
// Bundle of the fetch unit's control-unit, instruction-memory and instruction-register signals.
// The fetch unit connects through the slave modport; the control side connects through the master modport.
interface fetch_if;
  logic        fetch_in;
  logic        redirect_in;
  logic [15:0] redirect_addr;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        il_out;
  logic [15:0] ins_out;
  logic [15:0] pc_out;
  logic        busy_out;
  logic        fault_out;

  modport slave (
    input  fetch_in, redirect_in, redirect_addr, mem_ack, mem_rdata,
    output mem_req, mem_addr, il_out, ins_out, pc_out, busy_out, fault_out
  );

  modport master (
    output fetch_in, redirect_in, redirect_addr, mem_ack, mem_rdata,
    input  mem_req, mem_addr, il_out, ins_out, pc_out, busy_out, fault_out
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: holds the PC, reads instruction memory with req/ack,
// and strobes each fetched word into the instruction register; faults if memory stalls.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          TIMEOUT  = 15
) (
  input  logic    clk,
  input  logic    rst_n,
  fetch_if.slave  bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, LOAD, FAULT} state_t;

  state_t        state_q, state_d;
  logic [15:0]   pc_q, pc_d;
  logic [15:0]   ins_q, ins_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          mem_req_q, mem_req_d;
  logic          il_q, il_d;
  logic          busy_q, busy_d;
  logic          fault_q, fault_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ins_d   = ins_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        if (bus.redirect_in) pc_d = bus.redirect_addr;
        if (bus.fetch_in) begin
          state_d = REQ;
          wait_d  = '0;
        end
      end
      REQ: begin
        // An ack in the last allowed cycle still wins over the timeout.
        if (bus.mem_ack) begin
          ins_d   = bus.mem_rdata;
          pc_d    = pc_q + 16'd1;
          state_d = LOAD;
        end else if (wait_q == CW'(TIMEOUT - 1)) begin
          state_d = FAULT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      LOAD:    state_d = IDLE;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each one comes straight from a flop.
  always_comb begin
    mem_req_d = (state_d == REQ);
    il_d      = (state_d == LOAD);
    busy_d    = (state_d == REQ) || (state_d == LOAD);
    fault_d   = (state_d == FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      ins_q     <= 16'h0000;
      wait_q    <= '0;
      mem_req_q <= 1'b0;
      il_q      <= 1'b0;
      busy_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ins_q     <= ins_d;
      wait_q    <= wait_d;
      mem_req_q <= mem_req_d;
      il_q      <= il_d;
      busy_q    <= busy_d;
      fault_q   <= fault_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = pc_q;
  assign bus.pc_out    = pc_q;
  assign bus.ins_out   = ins_q;
  assign bus.il_out    = il_q;
  assign bus.busy_out  = busy_q;
  assign bus.fault_out = fault_q;
endmodule
